// File: rtl/packet_injector_if.sv
// Downstream link between a packet source and a router local input port.
// The injector drives the master side, the router the slave side.
interface packet_injector_if;
    logic [25:0] PacketOut;
    logic        ReqDnStr;
    logic        DnStrFull;
    logic        GntDnStr;

    modport master (
        output PacketOut,
        output ReqDnStr,
        input  DnStrFull,
        input  GntDnStr
    );

    modport slave (
        input  PacketOut,
        input  ReqDnStr,
        output DnStrFull,
        output GntDnStr
    );
endinterface

// File: rtl/packet_injector.sv
// Paced traffic source for a router local port: builds 26-bit packets and hands them over with Req/Gnt.
// Define INJECTOR_LFSR_DEST_EN to draw destinations from an LFSR instead of the row-major walk.
module packet_injector #(
    parameter logic [5:0] ModuleID    = 6'b000_000,
    parameter int         MESH_X      = 3,
    parameter int         MESH_Y      = 3,
    parameter int         packetwidth = 26,
    parameter int         NUM_PACKETS = 16,
    parameter int         GAP_CYCLES  = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                Start,
    packet_injector_if.master   dn,
    output logic                Done,
    output logic [9:0]          SentCount
);

    localparam logic [9:0] NUM_P  = 10'(NUM_PACKETS);
    localparam logic [7:0] GAP_P  = 8'(GAP_CYCLES);
    localparam bit         SINGLE = (MESH_X == 1) && (MESH_Y == 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_GAP,
        S_ARB,
        S_REQ,
        S_DONE
    } state_t;

    state_t                   state_q, state_d;
    logic [packetwidth-1:0]   pkt_q, pkt_d;
    logic                     req_q, req_d;
    logic                     done_q, done_d;
    logic [9:0]               cnt_q, cnt_d;
    logic [9:0]               pid_q, pid_d;
    logic [7:0]               gap_q, gap_d;
    logic [5:0]               dest_cur;
    logic                     dest_bad;
    logic                     adv;

`ifdef INJECTOR_LFSR_DEST_EN
    logic [7:0] lfsr_q, lfsr_d;
    logic [2:0] lx, ly;

    function automatic logic [7:0] lfsr_step(input logic [7:0] l);
        return {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
    endfunction

    always_comb begin
        lx = 3'({29'd0, lfsr_q[2:0]} % MESH_X);
        ly = 3'({29'd0, lfsr_q[5:3]} % MESH_Y);
    end

    assign dest_cur = SINGLE ? ModuleID : {lx, ly};
    // A draw that lands on our own router is re-rolled while waiting in ARB
    assign dest_bad = !SINGLE && ({lx, ly} == ModuleID);
    assign lfsr_d   = (adv || (state_q == S_ARB && dest_bad)) ? lfsr_step(lfsr_q) : lfsr_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) lfsr_q <= 8'hA5;
        else        lfsr_q <= lfsr_d;
    end
`else
    localparam logic [2:0] XMAX = 3'(MESH_X - 1);
    localparam logic [2:0] YMAX = 3'(MESH_Y - 1);

    logic [5:0] dest_q, dest_d;

    // Row-major step over {x,y}: y runs fastest, wrapping back to {0,0}
    function automatic logic [5:0] next_dest(input logic [5:0] d);
        logic [2:0] x, y;
        x = d[5:3];
        y = d[2:0];
        if (y >= YMAX) begin
            y = 3'd0;
            x = (x >= XMAX) ? 3'd0 : x + 3'd1;
        end else begin
            y = y + 3'd1;
        end
        return {x, y};
    endfunction

    assign dest_cur = SINGLE ? ModuleID
                    : ((dest_q == ModuleID) ? next_dest(dest_q) : dest_q);
    assign dest_bad = 1'b0;
    assign dest_d   = adv ? next_dest(dest_cur) : dest_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) dest_q <= 6'd0;
        else        dest_q <= dest_d;
    end
`endif

    always_comb begin
        state_d = state_q;
        pkt_d   = pkt_q;
        req_d   = req_q;
        done_d  = done_q;
        cnt_d   = cnt_q;
        pid_d   = pid_q;
        gap_d   = gap_q;
        adv     = 1'b0;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (Start) begin
                    state_d = S_ARB;
                    cnt_d   = 10'd0;
                    done_d  = 1'b0;
                end
            end
            S_ARB: begin
                req_d = 1'b0;
                if (!dest_bad && !dn.DnStrFull) begin
                    pkt_d   = {1'b0, pid_q, ModuleID, dest_cur, pid_q[2:0]};
                    req_d   = 1'b1;
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                // Request and packet stay put, even under Full, until granted
                if (dn.GntDnStr) begin
                    req_d = 1'b0;
                    pid_d = pid_q + 10'd1;
                    cnt_d = cnt_q + 10'd1;
                    adv   = 1'b1;
                    if (cnt_q + 10'd1 == NUM_P) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = S_GAP;
                        gap_d   = GAP_P;
                    end
                end
            end
            S_GAP: begin
                if (gap_q == 8'd0) state_d = S_ARB;
                else               gap_d   = gap_q - 8'd1;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            pkt_q   <= '0;
            req_q   <= 1'b0;
            done_q  <= 1'b0;
            cnt_q   <= 10'd0;
            pid_q   <= 10'd0;
            gap_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            pkt_q   <= pkt_d;
            req_q   <= req_d;
            done_q  <= done_d;
            cnt_q   <= cnt_d;
            pid_q   <= pid_d;
            gap_q   <= gap_d;
        end
    end

    assign dn.PacketOut = pkt_q;
    assign dn.ReqDnStr  = req_q;
    assign Done         = done_q;
    assign SentCount    = cnt_q;

endmodule
